// File: rtl/maze_wall_server.sv
// Shared wall-lookup responder: round-robin arbitration of ghost tile queries
// onto a single-port synchronous maze ROM, returning up/down/left/right wall flags.
module maze_wall_server #(
    parameter int NUM_CLIENTS = 4,
    parameter int MAZE_W      = 28,
    parameter int MAZE_H      = 36
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CLIENTS-1:0]   req,
    input  logic [6*NUM_CLIENTS-1:0] reqX,
    input  logic [6*NUM_CLIENTS-1:0] reqY,
    input  logic                     doorOpen,
    output logic [NUM_CLIENTS-1:0]   ack,
    output logic [4*NUM_CLIENTS-1:0] walls,
    output logic                     busy,
    output logic                     romEn,
    output logic [9:0]               romAddr,
    input  logic [1:0]               romData
);

    localparam int         IDX_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam logic [5:0] X_LIM  = 6'(MAZE_W);
    localparam logic [5:0] Y_LIM  = 6'(MAZE_H);
    localparam logic [5:0] X_LAST = 6'(MAZE_W - 1);
    localparam logic [5:0] Y_LAST = 6'(MAZE_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_DN,
        S_LT,
        S_RT,
        S_LAST,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic [IDX_W-1:0] cur_idx;
    logic [5:0]       cur_x;
    logic [5:0]       cur_y;
    logic             up_flag;
    logic             dn_flag;
    logic             lt_flag;
    logic [3:0]       wall_nib [NUM_CLIENTS];
    logic [5:0]       req_x_arr [NUM_CLIENTS];
    logic [5:0]       req_y_arr [NUM_CLIENTS];

    logic       invalid_pos;
    logic       force_up;
    logic       force_dn;
    logic [5:0] up_y;
    logic [5:0] dn_y;
    logic [5:0] lt_x;
    logic [5:0] rt_x;
    logic       tile_blocked;
    logic       rt_flag;

    // y*28 built from shifts so no multiplier is inferred
    function automatic logic [9:0] tile_addr(input logic [5:0] x, input logic [5:0] y);
        logic [9:0] y10;
        logic [9:0] x10;
        y10 = {4'd0, y};
        x10 = {4'd0, x};
        return (y10 << 4) + (y10 << 3) + (y10 << 2) + x10;
    endfunction

    function automatic logic decode_tile(input logic [1:0] code, input logic door_open);
        logic blocked;
        blocked = 1'b0;
        case (code)
            2'd1:    blocked = 1'b1;
            2'd2:    blocked = ~door_open;
            default: blocked = 1'b0;
        endcase
        return blocked;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            req_x_arr[i] = reqX[6*i +: 6];
            req_y_arr[i] = reqY[6*i +: 6];
        end
    end

    // Round-robin search starting at the pointer
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_CLIENTS) begin
                cand = cand - NUM_CLIENTS;
            end
            cand_idx = IDX_W'(cand);
            if (!grant_valid && req[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign invalid_pos  = (cur_x >= X_LIM) || (cur_y >= Y_LIM);
    assign force_up     = invalid_pos || (cur_y == 6'd0);
    assign force_dn     = invalid_pos || (cur_y == Y_LAST);
    assign up_y         = cur_y - 6'd1;
    assign dn_y         = cur_y + 6'd1;
    assign lt_x         = (cur_x == 6'd0) ? X_LAST : cur_x - 6'd1;
    assign rt_x         = (cur_x == X_LAST) ? 6'd0 : cur_x + 6'd1;
    assign tile_blocked = decode_tile(romData, doorOpen);
    assign rt_flag      = invalid_pos | tile_blocked;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Each lookup state presents one neighbour address; forced slots skip the ROM
    always_comb begin
        state_next = state;
        romEn      = 1'b0;
        romAddr    = '0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (grant_valid) begin
                    state_next = S_UP;
                end
            end
            S_UP: begin
                state_next = S_DN;
                if (!force_up) begin
                    romEn   = 1'b1;
                    romAddr = tile_addr(cur_x, up_y);
                end
            end
            S_DN: begin
                state_next = S_LT;
                if (!force_dn) begin
                    romEn   = 1'b1;
                    romAddr = tile_addr(cur_x, dn_y);
                end
            end
            S_LT: begin
                state_next = S_RT;
                if (!invalid_pos) begin
                    romEn   = 1'b1;
                    romAddr = tile_addr(lt_x, cur_y);
                end
            end
            S_RT: begin
                state_next = S_LAST;
                if (!invalid_pos) begin
                    romEn   = 1'b1;
                    romAddr = tile_addr(rt_x, cur_y);
                end
            end
            S_LAST: state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Grant latch and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr  <= '0;
            cur_idx <= '0;
            cur_x   <= '0;
            cur_y   <= '0;
        end else if (state == S_IDLE && grant_valid) begin
            cur_idx <= grant_idx;
            cur_x   <= req_x_arr[grant_idx];
            cur_y   <= req_y_arr[grant_idx];
            rr_ptr  <= (grant_idx == IDX_W'(NUM_CLIENTS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // ROM data lags the address by one state, so each capture belongs to the previous slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_flag <= 1'b1;
            dn_flag <= 1'b1;
            lt_flag <= 1'b1;
            ack     <= '0;
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                wall_nib[i] <= 4'hF;
            end
        end else begin
            ack <= '0;
            case (state)
                S_DN:   up_flag <= force_up | tile_blocked;
                S_LT:   dn_flag <= force_dn | tile_blocked;
                S_RT:   lt_flag <= invalid_pos | tile_blocked;
                S_LAST: begin
                    wall_nib[cur_idx] <= {rt_flag, lt_flag, dn_flag, up_flag};
                    ack[cur_idx]      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            walls[4*i +: 4] = wall_nib[i];
        end
    end

endmodule

// File: tb/tb_maze_wall_server.sv
// Self-checking bench for maze_wall_server: directed scenarios plus randomized
// batches compared against a tile-level reference model and a behavioural ROM.
module tb_maze_wall_server;

    localparam int NC = 4;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [23:0] req_x;
    logic [23:0] req_y;
    logic        door_open;
    logic [3:0]  ack;
    logic [15:0] walls;
    logic        busy;
    logic        rom_en;
    logic [9:0]  rom_addr;
    logic [1:0]  rom_data = 2'b00;

    logic [1:0]  rom_mem [0:1023];
    int          cx [NC];
    int          cy [NC];
    int          model_ptr;
    logic [15:0] model_walls;
    int          total_checks;
    int          bad_checks;

    maze_wall_server dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .reqX     (req_x),
        .reqY     (req_y),
        .doorOpen (door_open),
        .ack      (ack),
        .walls    (walls),
        .busy     (busy),
        .romEn    (rom_en),
        .romAddr  (rom_addr),
        .romData  (rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous tile ROM: data appears the cycle after an enabled address
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_mem[rom_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic blocked(input logic [1:0] code, input logic door);
        return (code == 2'd1) || (code == 2'd2 && !door);
    endfunction

    function automatic logic [3:0] model_nibble(input int x, input int y, input logic door);
        logic up, dn, lt, rt;
        if (x >= 28 || y >= 36) return 4'hF;
        up = (y == 0)  ? 1'b1 : blocked(rom_mem[(y - 1) * 28 + x], door);
        dn = (y == 35) ? 1'b1 : blocked(rom_mem[(y + 1) * 28 + x], door);
        lt = blocked(rom_mem[y * 28 + (x + 27) % 28], door);
        rt = blocked(rom_mem[y * 28 + (x + 1) % 28], door);
        return {rt, lt, dn, up};
    endfunction

    function automatic logic slot_en(input int x, input int y, input int o);
        if (x >= 28 || y >= 36) return 1'b0;
        if (o == 0) return y != 0;
        if (o == 1) return y != 35;
        return 1'b1;
    endfunction

    function automatic int slot_addr(input int x, input int y, input int o);
        case (o)
            0:       return (y - 1) * 28 + x;
            1:       return (y + 1) * 28 + x;
            2:       return y * 28 + (x + 27) % 28;
            default: return y * 28 + (x + 1) % 28;
        endcase
    endfunction

    task automatic driveCoords();
        for (int i = 0; i < NC; i++) begin
            req_x[6*i +: 6] = 6'(cx[i]);
            req_y[6*i +: 6] = 6'(cy[i]);
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b1;
        req   = 4'b0000;
        repeat (2) @(negedge clk);
        checkOutput("rst_walls", walls, 16'hFFFF);
        checkOutput("rst_ack", ack, 4'b0000);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_rom_en", rom_en, 1'b0);
        checkOutput("rst_rom_addr", rom_addr, 10'd0);
        reset       = 1'b0;
        model_ptr   = 0;
        model_walls = 16'hFFFF;
        @(negedge clk);
    endtask

    // Raise a request mask, then check every cycle of every service against the model;
    // each client drops its request on the cycle its ack is seen.
    task automatic applyStimulus(input logic [3:0] mask, input logic door);
        int         order[$];
        int         p;
        logic [3:0] rem;
        p   = model_ptr;
        rem = mask;
        while (rem != 4'b0000) begin
            for (int i = 0; i < NC; i++) begin
                int c;
                c = (p + i) % NC;
                if ((rem & (4'b0001 << c)) != 4'b0000) begin
                    order.push_back(c);
                    rem = rem & ~(4'b0001 << c);
                    p   = (c + 1) % NC;
                    break;
                end
            end
        end
        model_ptr = p;
        driveCoords();
        door_open = door;
        req       = mask;
        for (int e = 0; e < 7 * order.size(); e++) begin
            int         o;
            int         c;
            logic       exp_en;
            logic [3:0] exp_ack;
            @(posedge clk);
            @(negedge clk);
            o       = e % 7;
            c       = order[e / 7];
            exp_ack = (o == 5) ? (4'b0001 << c) : 4'b0000;
            checkOutput("ack", ack, exp_ack);
            checkOutput("busy", busy, o != 6);
            exp_en = (o <= 3) && slot_en(cx[c], cy[c], o);
            checkOutput("rom_en", rom_en, exp_en);
            if (exp_en) checkOutput("rom_addr", rom_addr, slot_addr(cx[c], cy[c], o));
            if (o == 5) begin
                model_walls[4*c +: 4] = model_nibble(cx[c], cy[c], door);
                checkOutput("walls", walls, model_walls);
                req = req & ~(4'b0001 << c);
            end
        end
    endtask

    initial begin
        total_checks = 0;
        bad_checks   = 0;
        reset        = 1'b1;
        req          = 4'b0000;
        req_x        = '0;
        req_y        = '0;
        door_open    = 1'b0;
        model_ptr    = 0;
        model_walls  = 16'hFFFF;
        for (int i = 0; i < 1024; i++) rom_mem[i] = 2'd0;
        for (int i = 0; i < NC; i++) begin
            cx[i] = 0;
            cy[i] = 0;
        end

        applyReset();

        // Abort a service in LT with reset: no ack and walls left at reset value
        cx[1] = 3;
        cy[1] = 3;
        driveCoords();
        req = 4'b0010;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_lt_en", rom_en, 1'b1);
        checkOutput("abort_lt_addr", rom_addr, 10'd86);
        reset = 1'b1;
        req   = 4'b0000;
        #1;
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_ack", ack, 4'b0000);
        repeat (2) @(negedge clk);
        reset       = 1'b0;
        model_ptr   = 0;
        model_walls = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("abort_idle_ack", ack, 4'b0000);
            checkOutput("abort_idle_busy", busy, 1'b0);
        end
        checkOutput("abort_walls", walls, 16'hFFFF);

        // Client 0 at (1,1)
        rom_mem[1]  = 2'd1;
        rom_mem[57] = 2'd0;
        rom_mem[28] = 2'd1;
        rom_mem[30] = 2'd0;
        cx[0] = 1;
        cy[0] = 1;
        applyStimulus(4'b0001, 1'b0);
        checkOutput("c0_nibble", walls[3:0], 4'b0101);

        // Tunnel row on both maze edges
        for (int x = 0; x < 28; x++) rom_mem[17 * 28 + x] = 2'd3;
        cx[0] = 0;
        cy[0] = 17;
        cx[1] = 27;
        cy[1] = 17;
        applyStimulus(4'b0011, 1'b0);
        checkOutput("tunnel_c0_lr", walls[3:2], 2'b00);
        checkOutput("tunnel_c1_lr", walls[7:6], 2'b00);

        // Top row, bottom row, off-maze X
        cx[2] = 5;
        cy[2] = 0;
        cx[3] = 5;
        cy[3] = 35;
        cx[0] = 30;
        cy[0] = 5;
        applyStimulus(4'b1101, 1'b0);
        checkOutput("edge_up", walls[8], 1'b1);
        checkOutput("edge_down", walls[13], 1'b1);
        checkOutput("invalid_nibble", walls[3:0], 4'hF);

        // Full contention from a fresh pointer, then a sparse mask
        applyReset();
        for (int i = 0; i < NC; i++) begin
            cx[i] = $urandom_range(0, 27);
            cy[i] = $urandom_range(1, 34);
        end
        applyStimulus(4'b1111, 1'($urandom_range(0, 1)));
        applyStimulus(4'b0101, 1'b0);

        // Ghost-house door below client 1
        rom_mem[15 * 28 + 13] = 2'd2;
        cx[1] = 13;
        cy[1] = 14;
        applyStimulus(4'b0010, 1'b0);
        checkOutput("door_closed", walls[5], 1'b1);
        applyStimulus(4'b0010, 1'b1);
        checkOutput("door_open", walls[5], 1'b0);

        // Idle with no requests
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("idle_busy", busy, 1'b0);
            checkOutput("idle_rom_en", rom_en, 1'b0);
        end

        // Randomized maze and request batches
        for (int i = 0; i < 1024; i++) rom_mem[i] = 2'($urandom_range(0, 3));
        for (int b = 0; b < 25; b++) begin
            for (int i = 0; i < NC; i++) begin
                cx[i] = $urandom_range(0, 31);
                cy[i] = $urandom_range(0, 37);
            end
            applyStimulus(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/maze_wall_server.md
# maze_wall_server

Shared wall-lookup responder for the ghost AI blocks. Each ghost presents its current tile (X,Y) and receives the four neighbour wall flags (up/down/left/right) that drive its intersection decision. A round-robin arbiter serialises client requests onto the single-port synchronous maze tile ROM and handles tunnel wrap, maze edges, invalid positions and the ghost-house door.

## Interface
- NUM_CLIENTS, 4, number of requesting ghosts.
- MAZE_W, 28, maze width in tiles.
- MAZE_H, 36, maze height in tiles.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high.
- req  input  NUM_CLIENTS  per-client request level; held until that client's ack.
- reqX  input  6*NUM_CLIENTS  client i tile X in bits [6i+5:6i].
- reqY  input  6*NUM_CLIENTS  client i tile Y in bits [6i+5:6i].
- doorOpen  input  1  1 = ghost-house door tiles passable.
- ack  output  NUM_CLIENTS  one-cycle pulse; client's walls just updated.
- walls  output  4*NUM_CLIENTS  client i: bit 4i = up, 4i+1 = down, 4i+2 = left, 4i+3 = right; 1 = blocked. Held between updates.
- busy  output  1  high in every state except IDLE.
- romEn  output  1  ROM read enable (combinational from state).
- romAddr  output  10  ROM address = y*28 + x (combinational).
- romData  input  2  tile code, valid the cycle after the address is sampled: 0 = empty, 1 = wall, 2 = door, 3 = tunnel (passable).

## Operation
- Reset: state IDLE, walls all 1, ack 0, busy 0, romEn 0, romAddr 0, round-robin pointer 0. Reset mid-service aborts it: no ack, no walls update.
- FSM: IDLE -> UP -> DN -> LT -> RT -> LAST -> DONE -> IDLE.
- IDLE: starting at the pointer, grant the first client with req high. Latch its X/Y and its index. Set pointer = grant+1 mod NUM_CLIENTS. No request: stay in IDLE.
- UP/DN/LT/RT: each drives the address of one neighbour. Data captured the following cycle. Neighbour coordinates:
  - up (x, y-1); down (x, y+1).
  - left ((x==0) ? MAZE_W-1 : x-1, y); right ((x==MAZE_W-1) ? 0 : x+1, y).
- Forced-blocked slot: romEn low, result 1. Applies to up when y==0, and to down when y==MAZE_H-1.
- Invalid position (X >= MAZE_W or Y >= MAZE_H): all four slots forced blocked. romEn never asserted. The FSM still walks every state (constant latency).
- Tile decode at capture: empty/tunnel -> 0, wall -> 1, door -> !doorOpen. doorOpen is sampled at the capture edge.
- LAST -> DONE edge: write the four flags into the granted client's walls nibble and raise that client's ack bit. Other nibbles are untouched.
- req is sampled only in IDLE. A client still holding req after its ack re-competes.
- Address arithmetic: y*28 computed as (y<<4)+(y<<3)+(y<<2), 10-bit, with no overflow for y <= 35.

## Timing
- t0 = IDLE edge that grants. Each state lasts one cycle.
- ROM samples the up address at t1, down at t2, left at t3, right at t4.
- Captures occur at t2 (up), t3 (down), t4 (left), t5 (right).
- Walls update and ack rises at t5. Ack is high for the cycle [t5,t6).
- FSM returns to IDLE at t6. Earliest next grant is t7: 7-cycle service period.
- A client must drop req before t7 to avoid re-grant. Dropping at t6 in response to ack is sufficient.
- Simultaneous requests: strict round-robin. Never two acks in the same cycle.

## Test plan
- Reset -> walls = all 1s, ack = 0, busy = 0, romEn = 0. Assert reset during LT -> no ack, walls stay all 1s, state IDLE.
- Client 0 at (1,1). ROM: (1,0) = wall, (1,2) = empty, (0,1) = wall, (2,1) = empty.
  - romAddr sequence 1, 57, 28, 30 on t1..t4.
  - ack[0] at t5; walls[3:0] = 4'b0101.
- Tunnel wrap:
  - (0,17): left addr = 503, right addr = 477.
  - (27,17): left addr = 502, right addr = 476.
  - ROM row 17 = tunnel codes -> left = 0, right = 0.
- Edges and invalid position:
  - (5,0): romEn low during UP, up flag = 1.
  - (5,35): romEn low during DN, down flag = 1.
  - X = 30: romEn never high, nibble = 4'b1111, ack still at t5.
- Contention: req = 4'b1111 at once, each client dropping req on its ack.
  - Acks for clients 0, 1, 2, 3 at t5, t12, t19, t26.
  - Then req = 4'b0101 -> grants 0 then 2.
- Door: tile below client = code 2.
  - doorOpen = 0 -> down flag = 1.
  - Repeat with doorOpen = 1 -> down flag = 0.
